// File: rtl/mac_pkg.sv
// Shared constants and FSM encoding for the MAC subsystem.
package mac_pkg;

    localparam int unsigned PP_W   = 15;
    localparam int unsigned EXP_W  = 6;
    localparam int unsigned NUM_PP = 4;
    localparam int unsigned CNT_W  = 3;
    localparam int unsigned ACC_W  = PP_W + $clog2(NUM_PP);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StAcc  = 2'd1,
        StOut  = 2'd2
    } acc_state_e;

endpackage

// File: rtl/ADD.sv
// Ripple adder primitive; wraps modulo 2^W and reports its own gate count.
module ADD #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic [50:0]  number
);

    assign sum = a + b;

    // Five gates per full-adder bit.
    assign number = 51'(5 * W);

endmodule

// File: rtl/pp_acc_ctrl.sv
// Group-accumulation FSM and beat counter; issues load/accumulate enables and the
// forced-close flag.
module pp_acc_ctrl
    import mac_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    input  logic             i_last,
    input  logic             i_ready,
    output logic             o_ready,
    output logic             o_valid,
    output logic             load,
    output logic             accum,
    output logic [CNT_W-1:0] cnt,
    output logic             err_force,
    output logic [50:0]      number
);

    acc_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             force_q, force_d;

    assign cnt_inc = cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        force_d = force_q;
        load    = 1'b0;
        accum   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (i_valid) begin
                    load    = 1'b1;
                    cnt_d   = CNT_W'(1);
                    force_d = 1'b0;
                    state_d = i_last ? StOut : StAcc;
                end
            end
            StAcc: begin
                if (i_valid) begin
                    accum = 1'b1;
                    cnt_d = cnt_inc;
                    if (i_last) begin
                        state_d = StOut;
                    end else if (cnt_inc == CNT_W'(NUM_PP)) begin
                        state_d = StOut;
                        force_d = 1'b1;
                    end
                end
            end
            StOut: begin
                // No same-cycle acceptance of a new group: one bubble cycle.
                if (i_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            force_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            force_q <= force_d;
        end
    end

    assign o_ready   = (state_q != StOut);
    assign o_valid   = (state_q == StOut);
    assign cnt       = cnt_q;
    assign err_force = force_q;

    // State flops plus next-state decode, and a counter with incrementer/compare.
    assign number = 51'(12 + 6 * CNT_W);

endmodule

// File: rtl/pp_accumulator.sv
// Sums a group of aligned partial products sharing one exponent and presents
// {sum, exp, count, error flags} to the normalizer.
module pp_accumulator
    import mac_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [PP_W-1:0]  i_pp,
    input  logic [EXP_W-1:0] i_max_exp,
    input  logic             i_last,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [ACC_W-1:0] o_sum,
    output logic [EXP_W-1:0] o_exp,
    output logic [CNT_W-1:0] o_cnt,
    output logic [1:0]       o_err,
    output logic [50:0]      number
);

    logic             load, accum, err_force;
    logic [50:0]      ctrl_number, add_number;
    logic [ACC_W-1:0] pp_ext, add_sum;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [EXP_W-1:0] exp_q, exp_d;
    logic             err_exp_q, err_exp_d;

    pp_acc_ctrl u_ctrl (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_valid   (i_valid),
        .i_last    (i_last),
        .i_ready   (i_ready),
        .o_ready   (o_ready),
        .o_valid   (o_valid),
        .load      (load),
        .accum     (accum),
        .cnt       (o_cnt),
        .err_force (err_force),
        .number    (ctrl_number)
    );

    assign pp_ext = {{(ACC_W - PP_W){i_pp[PP_W-1]}}, i_pp};

    ADD #(
        .W (ACC_W)
    ) u_add (
        .a      (acc_q),
        .b      (pp_ext),
        .sum    (add_sum),
        .number (add_number)
    );

    always_comb begin
        acc_d     = acc_q;
        exp_d     = exp_q;
        err_exp_d = err_exp_q;
        if (load) begin
            acc_d     = pp_ext;
            exp_d     = i_max_exp;
            err_exp_d = 1'b0;
        end else if (accum) begin
            // A mismatched beat is still summed as given; only the flag records it.
            acc_d = add_sum;
            if (i_max_exp != exp_q) begin
                err_exp_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            acc_q     <= '0;
            exp_q     <= '0;
            err_exp_q <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            exp_q     <= exp_d;
            err_exp_q <= err_exp_d;
        end
    end

    assign o_sum  = acc_q;
    assign o_exp  = exp_q;
    assign o_err  = {err_force, err_exp_q};
    assign number = ctrl_number + add_number;

endmodule

// File: tb/tb_pp_accumulator.sv
// Directed bench for pp_accumulator with hand-computed expected values.
module tb_pp_accumulator;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [14:0] i_pp = '0;
    logic [5:0]  i_max_exp = '0;
    logic        i_last = 1'b0;
    logic        o_valid;
    logic        i_ready = 1'b0;
    logic [16:0] o_sum;
    logic [5:0]  o_exp;
    logic [2:0]  o_cnt;
    logic [1:0]  o_err;
    logic [50:0] number;

    int total = 0;
    int bad = 0;

    always #5 i_clk = ~i_clk;

    pp_accumulator dut (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_pp      (i_pp),
        .i_max_exp (i_max_exp),
        .i_last    (i_last),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_sum     (o_sum),
        .o_exp     (o_exp),
        .o_cnt     (o_cnt),
        .o_err     (o_err),
        .number    (number)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Offer one beat for exactly one cycle.
    task automatic beat(input logic [14:0] pp, input logic [5:0] e, input logic last);
        i_valid   = 1'b1;
        i_pp      = pp;
        i_max_exp = e;
        i_last    = last;
        tick();
        i_valid = 1'b0;
        i_last  = 1'b0;
    endtask

    task automatic drain();
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_sum", 32'(o_sum), 32'd0);
        chk("rst_exp", 32'(o_exp), 32'd0);
        chk("rst_cnt", 32'(o_cnt), 32'd0);
        chk("rst_err", 32'(o_err), 32'd0);
        i_rst_n = 1'b1;
        tick();
        chk("rst_ready", 32'(o_ready), 32'd1);

        // Normal group: 12288 + 3072 - 2048 + 1 = 13313
        beat(15'h3000, 6'd20, 1'b0);
        beat(15'h0C00, 6'd20, 1'b0);
        beat(15'h7800, 6'd20, 1'b0);
        chk("n_valid_early", 32'(o_valid), 32'd0);
        beat(15'h0001, 6'd20, 1'b1);
        chk("n_valid", 32'(o_valid), 32'd1);
        chk("n_sum", 32'(o_sum), 32'd13313);
        chk("n_exp", 32'(o_exp), 32'd20);
        chk("n_cnt", 32'(o_cnt), 32'd4);
        chk("n_err", 32'(o_err), 32'd0);
        drain();
        chk("n_idle", 32'(o_valid), 32'd0);

        // Single negative beat, then backpressure
        beat(15'h4001, 6'd7, 1'b1);
        chk("neg_valid", 32'(o_valid), 32'd1);
        chk("neg_sum", 32'(o_sum), 32'h1C001);
        chk("neg_cnt", 32'(o_cnt), 32'd1);
        chk("neg_err", 32'(o_err), 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_ready", 32'(o_ready), 32'd0);
            chk("bp_valid", 32'(o_valid), 32'd1);
            chk("bp_sum", 32'(o_sum), 32'h1C001);
            chk("bp_exp", 32'(o_exp), 32'd7);
        end
        i_ready   = 1'b1;
        i_valid   = 1'b1;
        i_pp      = 15'h0007;
        i_max_exp = 6'd9;
        i_last    = 1'b1;
        tick();
        i_ready = 1'b0;
        i_valid = 1'b0;
        i_last  = 1'b0;
        chk("bp_idle_valid", 32'(o_valid), 32'd0);
        chk("bp_idle_ready", 32'(o_ready), 32'd1);
        tick();
        chk("bp_not_taken", 32'(o_valid), 32'd0);
        chk("bp_sum_hold", 32'(o_sum), 32'h1C001);

        // Forced close at NUM_PP; fifth beat waits for the next IDLE
        for (int i = 0; i < 4; i++) beat(15'h0001, 6'd3, 1'b0);
        chk("fc_valid", 32'(o_valid), 32'd1);
        chk("fc_sum", 32'(o_sum), 32'd4);
        chk("fc_cnt", 32'(o_cnt), 32'd4);
        chk("fc_err", 32'(o_err), 32'b10);
        i_valid   = 1'b1;
        i_pp      = 15'h0001;
        i_max_exp = 6'd3;
        i_last    = 1'b1;
        tick();
        tick();
        chk("fc_hold_ready", 32'(o_ready), 32'd0);
        chk("fc_hold_sum", 32'(o_sum), 32'd4);
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        chk("fc_bubble", 32'(o_valid), 32'd0);
        tick();
        i_valid = 1'b0;
        i_last  = 1'b0;
        chk("fc5_valid", 32'(o_valid), 32'd1);
        chk("fc5_sum", 32'(o_sum), 32'd1);
        chk("fc5_cnt", 32'(o_cnt), 32'd1);
        chk("fc5_err", 32'(o_err), 32'b00);
        drain();

        // Exponent mismatch: sum still uses the beat, exp from first beat
        beat(15'd100, 6'd12, 1'b0);
        beat(15'd200, 6'd13, 1'b1);
        chk("em_valid", 32'(o_valid), 32'd1);
        chk("em_sum", 32'(o_sum), 32'd300);
        chk("em_exp", 32'(o_exp), 32'd12);
        chk("em_err", 32'(o_err), 32'b01);
        drain();

        // Reset mid-group discards the partial sum
        beat(15'd5, 6'd3, 1'b0);
        beat(15'd6, 6'd3, 1'b0);
        chk("mr_partial_cnt", 32'(o_cnt), 32'd2);
        i_rst_n = 1'b0;
        #1;
        chk("mr_sum", 32'(o_sum), 32'd0);
        chk("mr_exp", 32'(o_exp), 32'd0);
        chk("mr_cnt", 32'(o_cnt), 32'd0);
        chk("mr_err", 32'(o_err), 32'd0);
        chk("mr_valid", 32'(o_valid), 32'd0);
        #3;
        i_rst_n = 1'b1;
        tick();
        chk("mr_ready", 32'(o_ready), 32'd1);
        beat(15'd5, 6'd4, 1'b1);
        chk("mr_new_valid", 32'(o_valid), 32'd1);
        chk("mr_new_sum", 32'(o_sum), 32'd5);
        chk("mr_new_cnt", 32'(o_cnt), 32'd1);
        chk("mr_new_err", 32'(o_err), 32'd0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
